// File: rtl/regfile_commit_scheduler_if.sv
// Write-side bus between ROB/decode, the commit scheduler and the register file.
// master = ROB/decode/regfile environment, slave = regfile_commit_scheduler.
interface regfile_commit_scheduler_if #(
    parameter int DEPTH     = 8,
    parameter int ROB_TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 in_commit_valid0;
    logic                 in_commit_valid1;
    logic [4:0]           in_commit_reg0;
    logic [4:0]           in_commit_reg1;
    logic [ROB_TAG_W-1:0] in_commit_rob0;
    logic [ROB_TAG_W-1:0] in_commit_rob1;
    logic [31:0]          in_commit_value0;
    logic [31:0]          in_commit_value1;
    logic                 in_misbranch;
    logic                 out_commit_ready;
    logic                 in_rename_valid;
    logic [4:0]           in_rename_reg;
    logic [ROB_TAG_W-1:0] in_rename_rob;
    logic                 out_rename_ready;
    logic [4:0]           out_reg_dest_reg;
    logic [ROB_TAG_W-1:0] out_reg_dest_rob;
    logic [4:0]           out_reg_commit_reg;
    logic [ROB_TAG_W-1:0] out_reg_commit_rob;
    logic [31:0]          out_reg_commit_value;
    logic                 out_reg_misbranch;
    logic [CNT_W-1:0]     out_fifo_count;

    modport master (
        output in_commit_valid0, in_commit_valid1, in_commit_reg0, in_commit_reg1,
        output in_commit_rob0, in_commit_rob1, in_commit_value0, in_commit_value1,
        output in_misbranch, in_rename_valid, in_rename_reg, in_rename_rob,
        input  out_commit_ready, out_rename_ready, out_reg_dest_reg, out_reg_dest_rob,
        input  out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
        input  out_reg_misbranch, out_fifo_count
    );

    modport slave (
        input  in_commit_valid0, in_commit_valid1, in_commit_reg0, in_commit_reg1,
        input  in_commit_rob0, in_commit_rob1, in_commit_value0, in_commit_value1,
        input  in_misbranch, in_rename_valid, in_rename_reg, in_rename_rob,
        output out_commit_ready, out_rename_ready, out_reg_dest_reg, out_reg_dest_rob,
        output out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
        output out_reg_misbranch, out_fifo_count
    );
endinterface

// File: rtl/regfile_commit_scheduler.sv
// Queues up to two retired writes per cycle onto the single register-file commit port,
// gates rename writes, and drains then flushes on misbranch. Optional: COMMIT_BYPASS_EN.
module regfile_commit_scheduler #(
    parameter int DEPTH     = 8,
    parameter int ROB_TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    regfile_commit_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_NORMAL, ST_DRAIN, ST_FLUSH} state_t;

    typedef struct packed {
        logic [4:0]           reg_id;
        logic [ROB_TAG_W-1:0] rob;
        logic [31:0]          value;
    } entry_t;

    entry_t               mem_q [DEPTH];
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [4:0]           commit_reg_q, commit_reg_d;
    logic [ROB_TAG_W-1:0] commit_rob_q, commit_rob_d;
    logic [31:0]          commit_value_q, commit_value_d;
    logic                 misbranch_q, misbranch_d;

    entry_t           lane0_ent, lane1_ent, head;
    logic             commit_ready, rename_ready;
    logic             accept, bypass, push0, push1, pop;
    logic [PTR_W-1:0] wa0, wa1;

    assign lane0_ent = '{reg_id: bus.in_commit_reg0, rob: bus.in_commit_rob0, value: bus.in_commit_value0};
    assign lane1_ent = '{reg_id: bus.in_commit_reg1, rob: bus.in_commit_rob1, value: bus.in_commit_value1};
    assign head      = mem_q[rd_ptr_q];

    // Two free slots are required regardless of lane count, so a group is never split.
    assign commit_ready = (state_q == ST_NORMAL) && (count_q <= CNT_W'(DEPTH - 2));
    assign rename_ready = (state_q == ST_NORMAL);
    assign accept       = rdy && bus.in_commit_valid0 && commit_ready;

`ifdef COMMIT_BYPASS_EN
    assign bypass = accept && (bus.in_commit_reg0 != 5'd0) && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push0 = accept && (bus.in_commit_reg0 != 5'd0) && !bypass;
    assign push1 = accept && bus.in_commit_valid1 && (bus.in_commit_reg1 != 5'd0);
    assign pop   = rdy && (count_q != '0);
    assign wa0   = wr_ptr_q;
    assign wa1   = wr_ptr_q + PTR_W'(push0);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        commit_reg_d   = commit_reg_q;
        commit_rob_d   = commit_rob_q;
        commit_value_d = commit_value_q;
        misbranch_d    = misbranch_q;
        if (rdy) begin
            count_d        = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
            wr_ptr_d       = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
            commit_reg_d   = 5'd0;
            commit_rob_d   = '0;
            commit_value_d = 32'd0;
            misbranch_d    = 1'b0;
            if (pop) begin
                commit_reg_d   = head.reg_id;
                commit_rob_d   = head.rob;
                commit_value_d = head.value;
            end else if (bypass) begin
                commit_reg_d   = lane0_ent.reg_id;
                commit_rob_d   = lane0_ent.rob;
                commit_value_d = lane0_ent.value;
            end
            case (state_q)
                ST_NORMAL: if (accept && bus.in_misbranch) state_d = ST_DRAIN;
                // Flush only once every older commit has left the FIFO.
                ST_DRAIN: if (count_q == '0) begin
                    state_d     = ST_FLUSH;
                    misbranch_d = 1'b1;
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_NORMAL;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            commit_reg_q   <= 5'd0;
            commit_rob_q   <= '0;
            commit_value_q <= 32'd0;
            misbranch_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            commit_reg_q   <= commit_reg_d;
            commit_rob_q   <= commit_rob_d;
            commit_value_q <= commit_value_d;
            misbranch_q    <= misbranch_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push0) mem_q[wa0] <= lane0_ent;
        if (!rst && push1) mem_q[wa1] <= lane1_ent;
    end

    assign bus.out_commit_ready     = commit_ready;
    assign bus.out_rename_ready     = rename_ready;
    assign bus.out_reg_dest_reg     = (bus.in_rename_valid && rename_ready) ? bus.in_rename_reg : 5'd0;
    assign bus.out_reg_dest_rob     = (bus.in_rename_valid && rename_ready) ? bus.in_rename_rob : '0;
    assign bus.out_reg_commit_reg   = commit_reg_q;
    assign bus.out_reg_commit_rob   = commit_rob_q;
    assign bus.out_reg_commit_value = commit_value_q;
    assign bus.out_reg_misbranch    = misbranch_q;
    assign bus.out_fifo_count       = count_q;
endmodule
